// File: rtl/if_id_skid_pkg.sv
// ============================================================================
// Module : if_id_skid_pkg
// Brief  : Shared constants for the IF/ID skid buffer: reset levels, zero
//          word and the buffer state encodings.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package if_id_skid_pkg;

  localparam logic        RstEnable  = 1'b1;
  localparam logic        RstDisable = 1'b0;
  localparam logic [31:0] ZeroWord   = 32'h0000_0000;

  // State code equals the number of buffered entries, so occupancy is the
  // state register itself.
  localparam logic [1:0]  EMPTY = 2'd0;
  localparam logic [1:0]  ONE   = 2'd1;
  localparam logic [1:0]  TWO   = 2'd2;

endpackage

`default_nettype wire

// File: rtl/if_id_skid_pipe_slot.sv
// ============================================================================
// Module : pipe_slot
// Brief  : One buffer slot: valid bit plus pc/inst registers with load and
//          clear. An invalid entry is always stored as all-zero (nop).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_slot
  import if_id_skid_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clr,
  input  logic              i_ld,
  input  logic              i_valid,
  input  logic [ADDR_W-1:0] i_pc,
  input  logic [INST_W-1:0] i_inst,
  output logic              o_valid,
  output logic [ADDR_W-1:0] o_pc,
  output logic [INST_W-1:0] o_inst
);

  logic              r_valid;
  logic [ADDR_W-1:0] r_pc;
  logic [INST_W-1:0] r_inst;

  // Slot register: reset/clear win over load; loading an invalid entry zeroes data.
  always_ff @(posedge clk) begin
    if (rst == RstEnable || i_clr) begin
      r_valid <= 1'b0;
      r_pc    <= ADDR_W'(ZeroWord);
      r_inst  <= INST_W'(ZeroWord);
    end else if (i_ld) begin
      r_valid <= i_valid;
      r_pc    <= i_valid ? i_pc   : ADDR_W'(ZeroWord);
      r_inst  <= i_valid ? i_inst : INST_W'(ZeroWord);
    end
  end

  assign o_valid = r_valid;
  assign o_pc    = r_pc;
  assign o_inst  = r_inst;

endmodule

`default_nettype wire

// File: rtl/if_id_skid.sv
// ============================================================================
// Module : if_id_skid
// Brief  : Two-entry IF->ID skid buffer. The main slot drives the decode
//          outputs, the skid slot absorbs one overflow entry. if_ready comes
//          from registered state only. Also counts decode stall cycles.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_id_skid
  import if_id_skid_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid,
  output logic              if_ready,
  input  logic [ADDR_W-1:0] if_pc,
  input  logic [INST_W-1:0] if_inst,
  input  logic              flush,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [ADDR_W-1:0] id_pc,
  output logic [INST_W-1:0] id_inst,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [CNT_W-1:0]  r_stall_cnt;

  logic              w_in;
  logic              w_out;
  logic              w_main_ld;
  logic              w_main_from_skid;
  logic              w_skid_ld;
  logic              w_skid_clr;

  logic              w_main_valid;
  logic [ADDR_W-1:0] w_main_pc;
  logic [INST_W-1:0] w_main_inst;
  logic              w_skid_valid;
  logic [ADDR_W-1:0] w_skid_pc;
  logic [INST_W-1:0] w_skid_inst;

  logic              w_main_d_valid;
  logic [ADDR_W-1:0] w_main_d_pc;
  logic [INST_W-1:0] w_main_d_inst;

  assign w_in  = if_valid & if_ready;
  assign w_out = w_main_valid & id_ready;

  // State register: reset has priority over everything.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) r_state <= EMPTY;
    else                  r_state <= w_state_nxt;
  end

  // Next-state: flush empties the buffer and drops any same-cycle input.
  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = EMPTY;
    end else begin
      case (r_state)
        EMPTY:   if (w_in) w_state_nxt = ONE;
        ONE: begin
          if (w_in && !w_out)      w_state_nxt = TWO;
          else if (!w_in && w_out) w_state_nxt = EMPTY;
        end
        TWO:     if (w_out) w_state_nxt = ONE;
        default: w_state_nxt = EMPTY;
      endcase
    end
  end

  // Output/slot control decode from the current state and handshakes.
  always_comb begin
    if_ready         = (rst == RstDisable) && (r_state != TWO);
    w_main_ld        = 1'b0;
    w_main_from_skid = 1'b0;
    w_skid_ld        = 1'b0;
    w_skid_clr       = flush;
    case (r_state)
      EMPTY: w_main_ld = w_in;
      ONE: begin
        // Main advances on a consume (refilled from input or emptied);
        // input with no consume spills into the skid slot.
        w_main_ld = w_out;
        w_skid_ld = w_in & ~w_out;
      end
      TWO: begin
        w_main_ld        = w_out;
        w_main_from_skid = 1'b1;
        w_skid_clr       = flush | w_out;
      end
      default: w_main_ld = 1'b0;
    endcase
  end

  assign w_main_d_valid = w_main_from_skid ? w_skid_valid : w_in;
  assign w_main_d_pc    = w_main_from_skid ? w_skid_pc    : if_pc;
  assign w_main_d_inst  = w_main_from_skid ? w_skid_inst  : if_inst;

  pipe_slot #(.ADDR_W(ADDR_W), .INST_W(INST_W)) u_main (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (flush),
    .i_ld    (w_main_ld),
    .i_valid (w_main_d_valid),
    .i_pc    (w_main_d_pc),
    .i_inst  (w_main_d_inst),
    .o_valid (w_main_valid),
    .o_pc    (w_main_pc),
    .o_inst  (w_main_inst)
  );

  pipe_slot #(.ADDR_W(ADDR_W), .INST_W(INST_W)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_skid_clr),
    .i_ld    (w_skid_ld),
    .i_valid (if_valid),
    .i_pc    (if_pc),
    .i_inst  (if_inst),
    .o_valid (w_skid_valid),
    .o_pc    (w_skid_pc),
    .o_inst  (w_skid_inst)
  );

  // Saturating stall counter; flush does not touch it.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      r_stall_cnt <= '0;
    end else if (w_main_valid && !id_ready && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign id_valid  = w_main_valid;
  assign id_pc     = w_main_pc;
  assign id_inst   = w_main_inst;
  assign occupancy = r_state;
  assign stall_cnt = r_stall_cnt;

endmodule

`default_nettype wire
